alu_issue_ctrl: RTL and testbench

Command-side controller for the 32-bit ALU datapath. It accepts ALU commands over a valid/ready handshake and reads operands from an internal 8x32 operand register file. It drives the ALU's INST/A/B/SEL inputs and samples Z after a parameterised settle time. It writes the result back to the register file and returns it over a valid/ready result channel.

---
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU command issue controller with 8x32 operand register file
// Define ALU_ISSUE_ZFLAG_EN to add the RES_ZERO result flag output.
module alu_issue_ctrl #(
  parameter int unsigned LAT     = 0,
  parameter int unsigned NREG_AW = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [13:0]        CMD,
  input  logic               LD_EN,
  input  logic [NREG_AW-1:0] LD_ADDR,
  input  logic [31:0]        LD_DATA,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [31:0]        RES_DATA,
  output logic [NREG_AW-1:0] RES_RD,
  output logic [31:0]        ALU_A,
  output logic [31:0]        ALU_B,
  output logic [3:0]         ALU_INST,
  output logic               ALU_SEL,
  input  logic [31:0]        ALU_Z,
`ifdef ALU_ISSUE_ZFLAG_EN
  output logic               RES_ZERO,
`endif
  output logic               BUSY
);

  localparam int unsigned NREG  = 1 << NREG_AW;
  localparam logic [2:0]  LAT_C = 3'(LAT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [31:0]         rf_q [NREG];
  logic [31:0]         rf_d [NREG];
  logic [NREG_AW-1:0]  rd_q, rd_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic [3:0]          inst_q, inst_d;
  logic                sel_q, sel_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [31:0]         res_data_q, res_data_d;
  logic [NREG_AW-1:0]  res_rd_q, res_rd_d;
  logic                zero_q, zero_d;

  logic [NREG_AW-1:0]  cmd_rd, cmd_rs1, cmd_rs2;

  assign cmd_rd  = NREG_AW'(CMD[8:6]);
  assign cmd_rs1 = NREG_AW'(CMD[5:3]);
  assign cmd_rs2 = NREG_AW'(CMD[2:0]);

  always_comb begin
    state_d    = state_q;
    rf_d       = rf_q;
    rd_d       = rd_q;
    a_d        = a_q;
    b_d        = b_q;
    inst_d     = inst_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    zero_d     = zero_q;
    case (state_q)
      IDLE: begin
        if (LD_EN) rf_d[LD_ADDR] = LD_DATA;
        if (CMD_VALID) begin
          // A preload landing on an operand address in the accept cycle is forwarded.
          rd_d    = cmd_rd;
          a_d     = (LD_EN && (LD_ADDR == cmd_rs1)) ? LD_DATA : rf_q[cmd_rs1];
          b_d     = (LD_EN && (LD_ADDR == cmd_rs2)) ? LD_DATA : rf_q[cmd_rs2];
          inst_d  = CMD[13:10];
          sel_d   = CMD[9];
          cnt_d   = LAT_C;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          res_data_d = ALU_Z;
          res_rd_d   = rd_q;
          zero_d     = (ALU_Z == 32'd0);
          rf_d[rd_q] = ALU_Z;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (RES_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rf_q       <= '{default: '0};
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      inst_q     <= '0;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      inst_q     <= inst_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      zero_q     <= zero_d;
    end
  end

  assign CMD_READY = (state_q == IDLE);
  assign RES_VALID = (state_q == RESP);
  assign BUSY      = (state_q != IDLE);
  assign RES_DATA  = res_data_q;
  assign RES_RD    = res_rd_q;
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_INST  = inst_q;
  assign ALU_SEL   = sel_q;

`ifdef ALU_ISSUE_ZFLAG_EN
  assign RES_ZERO = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl (LAT=0 and LAT=3 instances)
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_f(input logic [3:0] i, input logic s,
                                        input logic [31:0] a, input logic [31:0] b);
    case (i)
      4'h0:    return a + b;
      4'h1:    return a & b;
      4'h4:    return a ^ b;
      4'h6:    return s ? b : a;
      4'h8:    return a - b;
      4'h9:    return a | b;
      default: return a + b;
    endcase
  endfunction

  // LAT=0 instance
  logic        rst0, cv0, cr0, ld_en0, rv0, rr0, sel0, busy0, zero0;
  logic [13:0] cmd0;
  logic [2:0]  ld_addr0, rrd0;
  logic [31:0] ld_data0, rdata0, a0, b0, z0;
  logic [3:0]  inst0;
  assign z0 = alu_f(inst0, sel0, a0, b0);

  alu_issue_ctrl #(.LAT(0), .NREG_AW(3)) u_dut0 (
    .CLK(clk), .RST(rst0), .CMD_VALID(cv0), .CMD_READY(cr0), .CMD(cmd0),
    .LD_EN(ld_en0), .LD_ADDR(ld_addr0), .LD_DATA(ld_data0),
    .RES_VALID(rv0), .RES_READY(rr0), .RES_DATA(rdata0), .RES_RD(rrd0),
    .ALU_A(a0), .ALU_B(b0), .ALU_INST(inst0), .ALU_SEL(sel0), .ALU_Z(z0),
`ifdef ALU_ISSUE_ZFLAG_EN
    .RES_ZERO(zero0),
`endif
    .BUSY(busy0)
  );

  // LAT=3 instance
  logic        rst3, cv3, cr3, ld_en3, rv3, rr3, sel3, busy3, zero3;
  logic [13:0] cmd3;
  logic [2:0]  ld_addr3, rrd3;
  logic [31:0] ld_data3, rdata3, a3, b3, z3;
  logic [3:0]  inst3;
  assign z3 = alu_f(inst3, sel3, a3, b3);

  alu_issue_ctrl #(.LAT(3), .NREG_AW(3)) u_dut3 (
    .CLK(clk), .RST(rst3), .CMD_VALID(cv3), .CMD_READY(cr3), .CMD(cmd3),
    .LD_EN(ld_en3), .LD_ADDR(ld_addr3), .LD_DATA(ld_data3),
    .RES_VALID(rv3), .RES_READY(rr3), .RES_DATA(rdata3), .RES_RD(rrd3),
    .ALU_A(a3), .ALU_B(b3), .ALU_INST(inst3), .ALU_SEL(sel3), .ALU_Z(z3),
`ifdef ALU_ISSUE_ZFLAG_EN
    .RES_ZERO(zero3),
`endif
    .BUSY(busy3)
  );

`ifndef ALU_ISSUE_ZFLAG_EN
  assign zero0 = 1'b0;
  assign zero3 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [2:0]  rd;
    logic        zero;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0]  inst;
    logic        sel;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        pre_en;
    logic [2:0]  pre_addr;
    logic [31:0] pre_data;
    logic        byp_en;
    logic [2:0]  byp_addr;
    logic [31:0] byp_data;
    logic [31:0] exp_data;
    logic        exp_zero;
    int          delay;
    logic        hold_ld;
  } vec_t;
  vec_t vecs[11];

  // Scoreboard: results popped on each result handshake of the LAT=0 instance
  always @(negedge clk) begin
    if (!rst0 && rv0 && rr0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %h expected no result", rdata0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_data", rdata0, e.data);
        chk("sb_rd", {29'd0, rrd0}, {29'd0, e.rd});
`ifdef ALU_ISSUE_ZFLAG_EN
        chk("sb_zero", {31'd0, zero0}, {31'd0, e.zero});
`endif
      end
    end
  end

  task automatic run0(input vec_t v);
    int n;
    exp_t e;
    if (v.pre_en) begin
      ld_en0 = 1'b1; ld_addr0 = v.pre_addr; ld_data0 = v.pre_data;
      @(posedge clk); #1;
      ld_en0 = 1'b0;
    end
    chk("cmd_ready_idle", {31'd0, cr0}, 32'd1);
    cv0 = 1'b1;
    cmd0 = {v.inst, v.sel, v.rd, v.rs1, v.rs2};
    ld_en0 = v.byp_en; ld_addr0 = v.byp_addr; ld_data0 = v.byp_data;
    e.data = v.exp_data; e.rd = v.rd; e.zero = v.exp_zero;
    sbq.push_back(e);
    @(posedge clk); #1;
    cv0 = 1'b0; ld_en0 = 1'b0;
    n = 0;
    while (!rv0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency0", n, 32'd1);
    for (int k = 0; k < v.delay; k++) begin
      ld_en0 = v.hold_ld; ld_addr0 = 3'd3; ld_data0 = 32'hDEAD_BEEF;
      chk("hold_valid", {31'd0, rv0}, 32'd1);
      chk("hold_data", rdata0, v.exp_data);
      chk("hold_rd", {29'd0, rrd0}, {29'd0, v.rd});
      chk("hold_cmd_ready", {31'd0, cr0}, 32'd0);
      chk("hold_busy", {31'd0, busy0}, 32'd1);
      @(posedge clk); #1;
    end
    ld_en0 = 1'b0;
    rr0 = 1'b1;
    @(posedge clk); #1;
    rr0 = 1'b0;
    chk("valid_drop", {31'd0, rv0}, 32'd0);
  endtask

  task automatic ld3(input logic [2:0] addr, input logic [31:0] data);
    ld_en3 = 1'b1; ld_addr3 = addr; ld_data3 = data;
    @(posedge clk); #1;
    ld_en3 = 1'b0;
  endtask

  task automatic issue3(input logic [3:0] inst, input logic sel, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [31:0] exp_a, input logic [31:0] exp_b,
                        input logic [31:0] exp_z);
    int n;
    chk("c3_idle", {31'd0, cr3}, 32'd1);
    cv3 = 1'b1;
    cmd3 = {inst, sel, rd, rs1, rs2};
    @(posedge clk); #1;
    cv3 = 1'b0;
    n = 0;
    while (!rv3 && n < 20) begin
      chk("exec_a", a3, exp_a);
      chk("exec_b", b3, exp_b);
      chk("exec_inst", {28'd0, inst3}, {28'd0, inst});
      chk("exec_busy", {31'd0, busy3}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    chk("latency3", n, 32'd4);
    chk("res3_data", rdata3, exp_z);
    chk("res3_rd", {29'd0, rrd3}, {29'd0, rd});
    rr3 = 1'b1;
    @(posedge clk); #1;
    rr3 = 1'b0;
    chk("res3_drop", {31'd0, rv3}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    rst0 = 1'b1; cv0 = 1'b0; cmd0 = '0; ld_en0 = 1'b0; ld_addr0 = '0; ld_data0 = '0; rr0 = 1'b0;
    rst3 = 1'b1; cv3 = 1'b0; cmd3 = '0; ld_en3 = 1'b0; ld_addr3 = '0; ld_data3 = '0; rr3 = 1'b0;

    //            inst   sel   rd    rs1   rs2   pre   paddr pdata         byp   baddr bdata         exp           z     dly hold
    vecs[0]  = '{4'h0, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,        32'h8,        1'b0, 0, 1'b0};
    vecs[1]  = '{4'h6, 1'b0, 3'd4, 3'd3, 3'd0, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,        32'h8,        1'b0, 2, 1'b0};
    vecs[2]  = '{4'h8, 1'b0, 3'd5, 3'd1, 3'd2, 1'b1, 3'd1, 32'h0,        1'b1, 3'd2, 32'h1,        32'hFFFF_FFFF, 1'b0, 0, 1'b0};
    vecs[3]  = '{4'h9, 1'b0, 3'd6, 3'd1, 3'd2, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,        32'h1,        1'b0, 1, 1'b0};
    vecs[4]  = '{4'h0, 1'b0, 3'd1, 3'd5, 3'd6, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,        32'h0,        1'b1, 0, 1'b0};
    vecs[5]  = '{4'h4, 1'b0, 3'd5, 3'd4, 3'd4, 1'b0, 3'd0, 32'h0,        1'b1, 3'd4, 32'h1234,     32'h0,        1'b1, 0, 1'b0};
    vecs[6]  = '{4'h6, 1'b1, 3'd7, 3'd1, 3'd4, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,        32'h1234,     1'b0, 0, 1'b0};
    vecs[7]  = '{4'h0, 1'b0, 3'd2, 3'd2, 3'd2, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,        32'h2,        1'b0, 0, 1'b0};
    vecs[8]  = '{4'h6, 1'b0, 3'd0, 3'd2, 3'd0, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,        32'h2,        1'b0, 0, 1'b0};
    vecs[9]  = '{4'h6, 1'b0, 3'd5, 3'd3, 3'd0, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,        32'h8,        1'b0, 6, 1'b1};
    vecs[10] = '{4'h6, 1'b0, 3'd6, 3'd3, 3'd0, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,        32'h8,        1'b0, 0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst3 = 1'b0;

    chk("rst_cmd_ready", {31'd0, cr0}, 32'd1);
    chk("rst_res_valid", {31'd0, rv0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_res_data", rdata0, 32'd0);
    chk("rst_alu_a", a0, 32'd0);
    chk("rst_alu_inst", {28'd0, inst0}, 32'd0);

    ld_en0 = 1'b1; ld_addr0 = 3'd1; ld_data0 = 32'd5;
    @(posedge clk); #1;
    ld_addr0 = 3'd2; ld_data0 = 32'd3;
    @(posedge clk); #1;
    ld_en0 = 1'b0;

    for (int i = 0; i < 11; i++) run0(vecs[i]);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 32'd0);

    for (int i = 0; i < 8; i++) ld3(3'(i), 32'h100 + 32'(i));
    issue3(4'h0, 1'b0, 3'd3, 3'd1, 3'd2, 32'h101, 32'h102, 32'h203);

    // Reset lands in the middle of EXEC: no writeback, no result.
    cv3 = 1'b1;
    cmd3 = {4'h8, 1'b0, 3'd4, 3'd5, 3'd6};
    @(posedge clk); #1;
    cv3 = 1'b0;
    @(posedge clk); #2;
    rst3 = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, rv3}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cr3}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy3}, 32'd0);
    chk("mid_rst_alu_a", a3, 32'd0);
    chk("mid_rst_alu_b", b3, 32'd0);
    chk("mid_rst_alu_inst", {28'd0, inst3}, 32'd0);
    chk("mid_rst_res_data", rdata3, 32'd0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rv3) seen = 1;
      @(posedge clk); #1;
    end
    chk("no_resp_after_rst", seen, 32'd0);
    for (int i = 0; i < 8; i++)
      issue3(4'h6, 1'b0, 3'(i), 3'(i), 3'd0, 32'd0, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
